// File: rtl/workload_pkg.sv
// workload_pkg: shared types and constants for the workload sink.
//   workload_s        : {id, size} workload word as carried on the pipeline
//   e_err_*           : bit positions inside the sticky err_o vector
//   lfsr_seed/taps    : backpressure LFSR reset value and feedback mask
//   lfsr_next()       : one step of the 8-bit Fibonacci LFSR
package workload_pkg;

  localparam int wl_id_w   = 8;
  localparam int wl_size_w = 8;

  typedef struct packed {
    logic [wl_id_w-1:0]   id;
    logic [wl_size_w-1:0] size;
  } workload_s;

  localparam int e_err_dup     = 0;
  localparam int e_err_unknown = 1;
  localparam int e_err_order   = 2;
  localparam int e_err_size    = 3;

  // Taps 8,6,5,4 map to state bits 7,5,4,3.
  localparam logic [7:0] lfsr_seed = 8'h01;
  localparam logic [7:0] lfsr_taps = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & lfsr_taps)};
  endfunction

endpackage

// File: rtl/workload_sink_table.sv
// workload_sink_table: outstanding-workload storage, els_p entries of
// {valid, size, stamp}.
//   clk_i, reset_i   : clock, synchronous active-high reset (clears valid only)
//   wr_en/idx/size/stamp : issue write port, wr_hit = entry valid before write
//   rd_idx, rd_clr   : completion read-and-clear port
//   rd_valid/size/stamp : pre-update contents of entry rd_idx
// When both ports hit the same index in one cycle the clear is applied first
// and the write wins, so the entry ends up holding the new issue.
module workload_sink_table #(
  parameter int els_p         = 16,
  parameter int size_width_p  = 8,
  parameter int cycle_width_p = 32,
  localparam int lg_els_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en,
  input  logic [lg_els_lp-1:0]     wr_idx,
  input  logic [size_width_p-1:0]  wr_size,
  input  logic [cycle_width_p-1:0] wr_stamp,
  output logic                     wr_hit,
  input  logic [lg_els_lp-1:0]     rd_idx,
  input  logic                     rd_clr,
  output logic                     rd_valid,
  output logic [size_width_p-1:0]  rd_size,
  output logic [cycle_width_p-1:0] rd_stamp
);

  logic [els_p-1:0]         valid_r;
  logic [size_width_p-1:0]  size_r  [els_p];
  logic [cycle_width_p-1:0] stamp_r [els_p];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_r <= '0;
    end else begin
      if (rd_clr) valid_r[rd_idx] <= 1'b0;
      if (wr_en)  valid_r[wr_idx] <= 1'b1;
    end
  end

  // Payload is only meaningful while valid is set, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      size_r[wr_idx]  <= wr_size;
      stamp_r[wr_idx] <= wr_stamp;
    end
  end

  assign wr_hit   = valid_r[wr_idx];
  assign rd_valid = valid_r[rd_idx];
  assign rd_size  = size_r[rd_idx];
  assign rd_stamp = stamp_r[rd_idx];

endmodule

// File: rtl/workload_sink.sv
// workload_sink: end-of-pipeline consumer and checker.
// Snoops the pipeline input handshake to timestamp issued workloads, accepts
// completions, and reports in-order completion, latency statistics and
// sticky error flags.
//   clk_i, reset_i            : clock, synchronous active-high reset
//   issue_v_i/ready_i/data_i  : snooped pipeline-input handshake, {id, size}
//   v_i, data_i, ready_o      : completion handshake, {id, size}
//   done_count_o              : accepted completions of known workloads (sat.)
//   latency_sum_o/max_o       : latency statistics (sum saturates)
//   all_done_o                : done_count_o == workload_limit_p
//   err_o                     : sticky {size, order, unknown, duplicate}
// Build option: define WORKLOAD_SINK_BACKPRESSURE_EN to drive ready_o from an
// 8-bit LFSR instead of holding it high.
module workload_sink
  import workload_pkg::*;
#(
  parameter int id_width_p       = 8,
  parameter int size_width_p     = 8,
  parameter int els_p            = 16,
  parameter int cycle_width_p    = 32,
  parameter int workload_limit_p = 16
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                issue_v_i,
  input  logic                                issue_ready_i,
  input  logic [id_width_p+size_width_p-1:0]  issue_data_i,
  input  logic                                v_i,
  input  logic [id_width_p+size_width_p-1:0]  data_i,
  output logic                                ready_o,
  output logic [cycle_width_p-1:0]            done_count_o,
  output logic [cycle_width_p-1:0]            latency_sum_o,
  output logic [cycle_width_p-1:0]            latency_max_o,
  output logic                                all_done_o,
  output logic [3:0]                          err_o
);

  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int word_w_lp = id_width_p + size_width_p;

  function automatic logic [cycle_width_p-1:0] sat_add(
    input logic [cycle_width_p-1:0] a,
    input logic [cycle_width_p-1:0] b
  );
    logic [cycle_width_p:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[cycle_width_p] ? '1 : s[cycle_width_p-1:0];
  endfunction

  function automatic logic [cycle_width_p-1:0] sat_inc(
    input logic [cycle_width_p-1:0] a
  );
    return (&a) ? a : a + 1'b1;
  endfunction

  logic [id_width_p-1:0]    issue_id, cpl_id;
  logic [size_width_p-1:0]  issue_size, cpl_size;
  logic                     issue_fire, cpl_fire;

  logic [cycle_width_p-1:0] cyc_r, done_r, sum_r, max_r;
  logic [id_width_p-1:0]    exp_id_r;
  logic [3:0]               err_r;
  logic                     ready_r;

  logic                     wr_hit, rd_valid, dup_hit;
  logic [size_width_p-1:0]  rd_size;
  logic [cycle_width_p-1:0] rd_stamp, latency;

  assign issue_id   = issue_data_i[word_w_lp-1:size_width_p];
  assign issue_size = issue_data_i[size_width_p-1:0];
  assign cpl_id     = data_i[word_w_lp-1:size_width_p];
  assign cpl_size   = data_i[size_width_p-1:0];

  assign issue_fire = issue_v_i & issue_ready_i;
  assign cpl_fire   = v_i & ready_r;

  // Only the low id bits select a table entry.
  if (id_width_p > lg_els_lp) begin : g_id_hi
    logic unused_issue_id_hi;
    assign unused_issue_id_hi = ^issue_id[id_width_p-1:lg_els_lp];
  end

  workload_sink_table #(
    .els_p         (els_p),
    .size_width_p  (size_width_p),
    .cycle_width_p (cycle_width_p)
  ) u_table (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wr_en    (issue_fire),
    .wr_idx   (issue_id[lg_els_lp-1:0]),
    .wr_size  (issue_size),
    .wr_stamp (cyc_r),
    .wr_hit   (wr_hit),
    .rd_idx   (cpl_id[lg_els_lp-1:0]),
    .rd_clr   (cpl_fire),
    .rd_valid (rd_valid),
    .rd_size  (rd_size),
    .rd_stamp (rd_stamp)
  );

  // An entry retired by a completion in the same cycle is free for reuse,
  // so a same-index issue then is not a duplicate.
  assign dup_hit = issue_fire & wr_hit &
                   ~(cpl_fire & (cpl_id[lg_els_lp-1:0] == issue_id[lg_els_lp-1:0]));

  // Modulo subtraction tolerates counter wrap between issue and completion.
  assign latency = cyc_r - rd_stamp;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cyc_r    <= '0;
      done_r   <= '0;
      sum_r    <= '0;
      max_r    <= '0;
      exp_id_r <= '0;
      err_r    <= '0;
    end else begin
      cyc_r <= cyc_r + 1'b1;
      if (dup_hit) err_r[e_err_dup] <= 1'b1;
      if (cpl_fire) begin
        exp_id_r <= exp_id_r + 1'b1;
        if (cpl_id != exp_id_r) err_r[e_err_order] <= 1'b1;
        if (rd_valid) begin
          done_r <= sat_inc(done_r);
          sum_r  <= sat_add(sum_r, latency);
          if (latency > max_r) max_r <= latency;
          if (cpl_size != rd_size) err_r[e_err_size] <= 1'b1;
        end else begin
          err_r[e_err_unknown] <= 1'b1;
        end
      end
    end
  end

`ifdef WORKLOAD_SINK_BACKPRESSURE_EN
  logic [7:0] lfsr_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_r  <= lfsr_seed;
      ready_r <= 1'b0;
    end else begin
      lfsr_r  <= lfsr_next(lfsr_r);
      ready_r <= lfsr_r[0];
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (reset_i) ready_r <= 1'b0;
    else         ready_r <= 1'b1;
  end
`endif

  assign ready_o       = ready_r;
  assign done_count_o  = done_r;
  assign latency_sum_o = sum_r;
  assign latency_max_o = max_r;
  assign err_o         = err_r;
  assign all_done_o    = (done_r == cycle_width_p'(workload_limit_p));

endmodule

// File: tb/tb_workload_sink.sv
module tb_workload_sink;
  import workload_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, iv, ird, cv;
  logic [15:0] idata, cdata;
  logic        rdy, alld;
  logic [31:0] done, lsum, lmax;
  logic [3:0]  err;

  logic        wrst, wiv, wcv;
  logic [15:0] widata, wcdata;
  logic        wrdy, walld;
  logic [3:0]  wdone, wsum, wmax, werr;

  workload_sink #(
    .id_width_p(8), .size_width_p(8), .els_p(16),
    .cycle_width_p(32), .workload_limit_p(16)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .issue_v_i(iv), .issue_ready_i(ird), .issue_data_i(idata),
    .v_i(cv), .data_i(cdata), .ready_o(rdy),
    .done_count_o(done), .latency_sum_o(lsum), .latency_max_o(lmax),
    .all_done_o(alld), .err_o(err)
  );

  workload_sink #(
    .id_width_p(8), .size_width_p(8), .els_p(16),
    .cycle_width_p(4), .workload_limit_p(3)
  ) dutw (
    .clk_i(clk), .reset_i(wrst),
    .issue_v_i(wiv), .issue_ready_i(1'b1), .issue_data_i(widata),
    .v_i(wcv), .data_i(wcdata), .ready_o(wrdy),
    .done_count_o(wdone), .latency_sum_o(wsum), .latency_max_o(wmax),
    .all_done_o(walld), .err_o(werr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         r;
    bit         iv;
    int         iid, isz;
    bit         cv;
    int         cid, csz;
    int         e_done, e_sum, e_max;
    logic [3:0] e_err, mask;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pack(input int id, input int sz);
    workload_s w;
    w.id   = 8'(id);
    w.size = 8'(sz);
    return w;
  endfunction

  function automatic logic [7:0] model_lfsr(input logic [7:0] m);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  endfunction

  function automatic vec_t mk(input bit r, input bit iv_, input int iid, input int isz,
                              input bit cv_, input int cid, input int csz,
                              input int ed, input int es, input int em,
                              input logic [3:0] ee, input logic [3:0] mask);
    vec_t v;
    v.r = r; v.iv = iv_; v.iid = iid; v.isz = isz;
    v.cv = cv_; v.cid = cid; v.csz = csz;
    v.e_done = ed; v.e_sum = es; v.e_max = em; v.e_err = ee; v.mask = mask;
    return v;
  endfunction

  task automatic main_reset();
    rst = 1'b1; iv = 1'b0; cv = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q_id[$];
    int q_due[$];
    int t, issued, acc;
    bit accept;
    logic [7:0] m;
    int wc;

    rst = 1'b1; iv = 1'b0; ird = 1'b1; cv = 1'b0; idata = '0; cdata = '0;
    wrst = 1'b1; wiv = 1'b0; wcv = 1'b0; widata = '0; wcdata = '0;

    // Reset state, observed in the cycle reset deasserts.
    main_reset();
    check("rst_ready", {31'b0, rdy}, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_sum", lsum, 32'd0);
    check("rst_max", lmax, 32'd0);
    check("rst_err", {28'b0, err}, 32'd0);
    check("rst_alldone", {31'b0, alld}, 32'd0);

`ifdef WORKLOAD_SINK_BACKPRESSURE_EN
    m = 8'h01;
    for (int i = 0; i < 30; i++) begin
      tick();
      check($sformatf("lfsr_ready%0d", i), {31'b0, rdy}, {31'b0, m[0]});
      m = model_lfsr(m);
    end
    main_reset();
`endif

    // Basic run: ids 0..15 issued back to back, each completed 5 cycles later
    // (or as soon as ready allows).
    t = 0; issued = 0; acc = 0;
    while ((issued < 16 || q_id.size() > 0) && t < 600) begin
      iv = (issued < 16);
      idata = pack(issued, issued);
      cv = 1'b0;
      if (q_id.size() > 0 && q_due[0] <= t) begin
        cv = 1'b1;
        cdata = pack(q_id[0], q_id[0]);
      end
      accept = cv & rdy;
      tick();
      if (iv) begin
        q_id.push_back(issued);
        q_due.push_back(t + 5);
        issued++;
      end
      if (accept) begin
        void'(q_id.pop_front());
        void'(q_due.pop_front());
        acc++;
      end
      check($sformatf("run_done_t%0d", t), done, 32'(acc));
      t++;
    end
    iv = 1'b0; cv = 1'b0;
    check("run_timeout", {31'b0, t >= 600}, 32'd0);
    check("run_done", done, 32'd16);
    check("run_alldone", {31'b0, alld}, 32'd1);
    check("run_err", {28'b0, err}, 32'd0);
`ifndef WORKLOAD_SINK_BACKPRESSURE_EN
    check("run_sum", lsum, 32'd80);
    check("run_max", lmax, 32'd5);

    // Directed per-cycle vectors; each row is one clock.
    // Duplicate issue of id 3, completion counted once from the second stamp.
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,3,3, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,3,3, 0,0,0, 0,0,0, 4'h1, 4'hF));
    vecs.push_back(mk(0,0,0,0, 1,3,3, 1,1,1, 4'h5, 4'hF));
    vecs.push_back(mk(0,0,0,0, 1,3,3, 1,1,1, 4'h7, 4'hF));
    // Unknown completion of id 7 (exp_id 0), then of id 0 (exp_id 0).
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 1,7,0, 0,0,0, 4'h6, 4'hF));
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 1,0,0, 0,0,0, 4'h2, 4'hF));
    // Out of order (1 before 0), then size mismatch on id 2.
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,0,1, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,1,1, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 1,1,1, 1,1,1, 4'h4, 4'hF));
    vecs.push_back(mk(0,0,0,0, 1,0,1, 2,4,3, 4'h4, 4'hF));
    vecs.push_back(mk(0,1,2,4, 0,0,0, 2,4,3, 4'h4, 4'hF));
    vecs.push_back(mk(0,0,0,0, 1,2,5, 3,5,3, 4'hC, 4'hF));
    // Same-cycle issue and completion of id 2: old entry retired, new kept.
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,2,9, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,2,9, 1,2,9, 1,2,2, 4'h4, 4'hE));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 1,2,2, 4'h4, 4'hE));
    vecs.push_back(mk(0,0,0,0, 1,2,9, 2,4,2, 4'h4, 4'hE));
    vecs.push_back(mk(0,0,0,0, 1,2,9, 2,4,2, 4'h6, 4'hE));
    // Reset with three workloads outstanding; old id 0 is then unknown.
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,1,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,1,2,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 4'h0, 4'hF));
    vecs.push_back(mk(0,0,0,0, 1,0,0, 0,0,0, 4'h2, 4'hF));

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].r;
      iv    = vecs[i].iv;
      idata = pack(vecs[i].iid, vecs[i].isz);
      cv    = vecs[i].cv;
      cdata = pack(vecs[i].cid, vecs[i].csz);
      tick();
      check($sformatf("row%0d_done", i), done, 32'(vecs[i].e_done));
      check($sformatf("row%0d_sum", i), lsum, 32'(vecs[i].e_sum));
      check($sformatf("row%0d_max", i), lmax, 32'(vecs[i].e_max));
      check($sformatf("row%0d_err", i), {28'b0, err & vecs[i].mask},
            {28'b0, vecs[i].e_err & vecs[i].mask});
      check($sformatf("row%0d_ready", i), {31'b0, rdy}, {31'b0, ~vecs[i].r});
      check($sformatf("row%0d_alldone", i), {31'b0, alld}, {31'b0, vecs[i].e_done == 16});
    end
    rst = 1'b0; iv = 1'b0; cv = 1'b0;

    // 4-bit cycle counter: latency across wrap and saturating latency sum.
    wrst = 1'b1;
    tick();
    tick();
    wrst = 1'b0;
    wc = 0;
    while (wc != 14) begin tick(); wc = (wc + 1) & 15; end
    wiv = 1'b1; widata = pack(0, 0);
    tick(); wc = (wc + 1) & 15;
    wiv = 1'b0;
    while (wc != 2) begin tick(); wc = (wc + 1) & 15; end
    wcv = 1'b1; wcdata = pack(0, 0);
    tick(); wc = (wc + 1) & 15;
    wcv = 1'b0;
    check("wrap_done", {28'b0, wdone}, 32'd1);
    check("wrap_sum", {28'b0, wsum}, 32'd4);
    check("wrap_max", {28'b0, wmax}, 32'd4);
    check("wrap_err", {28'b0, werr}, 32'd0);

    wiv = 1'b1; widata = pack(1, 0);
    tick(); wc = (wc + 1) & 15;
    wiv = 1'b0;
    while (wc != 14) begin tick(); wc = (wc + 1) & 15; end
    wcv = 1'b1; wcdata = pack(1, 0);
    tick(); wc = (wc + 1) & 15;
    wcv = 1'b0;
    check("wrap2_sum", {28'b0, wsum}, 32'd15);
    check("wrap2_max", {28'b0, wmax}, 32'd11);

    wiv = 1'b1; widata = pack(2, 0);
    tick(); wc = (wc + 1) & 15;
    wiv = 1'b0;
    while (wc != 2) begin tick(); wc = (wc + 1) & 15; end
    wcv = 1'b1; wcdata = pack(2, 0);
    tick(); wc = (wc + 1) & 15;
    wcv = 1'b0;
    check("sat_sum", {28'b0, wsum}, 32'd15);
    check("sat_max", {28'b0, wmax}, 32'd11);
    check("sat_done", {28'b0, wdone}, 32'd3);
    check("sat_alldone", {31'b0, walld}, 32'd1);
    check("sat_err", {28'b0, werr}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
